// File: rtl/vga_scan_if.sv
// ============================================================
// Interface : vga_scan_if
// Brief     : Scan coordinates, returned colour and pin-level VGA outputs.
// Rev       : 1.0 - initial release
// ============================================================
`default_nettype none

interface vga_scan_if;
  logic [15:0] icolor;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        hs;
  logic        vs;
  logic        video_on;
  logic        frame_start;

  modport master (
    input  icolor,
    output cx, cy, r, g, b, hs, vs, video_on, frame_start
  );

  modport slave (
    output icolor,
    input  cx, cy, r, g, b, hs, vs, video_on, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/vga_scan.sv
// ============================================================
// Module : vga_scan
// Brief  : VGA raster counters, sync decode and aligned RGB/sync output stage.
// Rev    : 1.0 - initial release
// ============================================================
`default_nettype none

module vga_scan #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  wire logic   clk,
  input  wire logic   rstn,
  vga_scan_if.master  bus
);

  localparam int              c_DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_div_last = c_DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] c_h_vis      = 10'(H_VIS);
  localparam logic [9:0] c_h_last     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_hs_start   = 10'(H_VIS + H_FP);
  localparam logic [9:0] c_hs_end     = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_v_vis      = 10'(V_VIS);
  localparam logic [9:0] c_v_last     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_vs_start   = 10'(V_VIS + V_FP);
  localparam logic [9:0] c_vs_end     = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [c_DIV_W-1:0] r_div;
  logic [9:0]         r_hcnt;
  logic [9:0]         r_vcnt;
  logic [3:0]         r_r;
  logic [3:0]         r_g;
  logic [3:0]         r_b;
  logic               r_hs;
  logic               r_vs;
  logic               r_video_on;

  logic w_pix_en;
  logic w_h_end;
  logic w_v_end;
  logic w_vis;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_unused;

  assign w_pix_en = (r_div == c_div_last);
  assign w_h_end  = (r_hcnt == c_h_last);
  assign w_v_end  = (r_vcnt == c_v_last);
  assign w_vis    = (r_hcnt < c_h_vis) && (r_vcnt < c_v_vis);
  assign w_hs_raw = !((r_hcnt >= c_hs_start) && (r_hcnt <= c_hs_end));
  assign w_vs_raw = !((r_vcnt >= c_vs_start) && (r_vcnt <= c_vs_end));
  assign w_unused = ^bus.icolor[15:12];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div  <= '0;
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_div <= w_pix_en ? '0 : r_div + 1'b1;
      if (w_pix_en) begin
        r_hcnt <= w_h_end ? 10'd0 : r_hcnt + 10'd1;
        if (w_h_end) begin
          r_vcnt <= w_v_end ? 10'd0 : r_vcnt + 10'd1;
        end
      end
    end
  end

  // Colour, blanking and syncs share one register stage so they reach the pins together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_r        <= 4'd0;
      r_g        <= 4'd0;
      r_b        <= 4'd0;
      r_hs       <= 1'b1;
      r_vs       <= 1'b1;
      r_video_on <= 1'b0;
    end else if (w_pix_en) begin
      r_r        <= w_vis ? bus.icolor[11:8] : 4'd0;
      r_g        <= w_vis ? bus.icolor[7:4]  : 4'd0;
      r_b        <= w_vis ? bus.icolor[3:0]  : 4'd0;
      r_hs       <= w_hs_raw;
      r_vs       <= w_vs_raw;
      r_video_on <= w_vis;
    end
  end

  assign bus.cx          = w_vis ? r_hcnt : 10'd0;
  assign bus.cy          = w_vis ? r_vcnt[8:0] : 9'd0;
  assign bus.r           = r_r;
  assign bus.g           = r_g;
  assign bus.b           = r_b;
  assign bus.hs          = r_hs;
  assign bus.vs          = r_vs;
  assign bus.video_on    = r_video_on;
  // High in the last clock of the frame; the counters land on (0,0) at its closing edge.
  assign bus.frame_start = w_pix_en && w_h_end && w_v_end;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan.sv
// ============================================================
// Module : tb_vga_scan
// Brief  : Directed bench: full-size timing unit plus a shrunken-frame unit.
// Rev    : 1.0 - initial release
// ============================================================
`default_nettype none

module tb_vga_scan;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  int          cyc;
  int          n_vec = 0;
  int          n_err = 0;
  int          err_cx = 0;
  int          err_pix = 0;
  int          err_sync = 0;
  int          err_blank = 0;
  int          n_vis_b, n_blk_b, fs_n, fs_run, fs_wmax, vs_fall, vs_rise;
  int          fs_t [2];
  logic        vs_prev;
  logic [15:0] r_d1, r_d2;

  vga_scan_if bus_a ();
  vga_scan_if bus_b ();

  vga_scan u_dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_a)
  );

  // 25 x 12 pixel frame: 100 clk per line, 1200 clk per frame
  vga_scan #(
    .CLK_DIV (4),
    .H_VIS   (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_VIS   (6),  .V_FP (2), .V_SYNC (2), .V_BP (2)
  ) u_dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Two-clock colour lookup for unit A
  always @(posedge clk) begin
    r_d1 <= {4'h0, bus_a.cx[3:0], bus_a.cy[3:0], 4'hA};
    r_d2 <= r_d1;
  end
  assign bus_a.icolor = r_d2;
  assign bus_b.icolor = 16'hFFFF;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference raster model for unit A, evaluated every clock
  always @(negedge clk) begin : mon_a
    int q, p, hq, vq, hp, vp;
    logic vis_q, vis_p, ehs, evs, evo, efs;
    logic [3:0] er, eg, eb;
    if (rstn) begin
      q     = cyc / 4;
      hq    = q % 800;
      vq    = (q / 800) % 525;
      vis_q = (hq < 640) && (vq < 480);
      if (bus_a.cx !== (vis_q ? 10'(hq) : 10'd0) || bus_a.cy !== (vis_q ? 9'(vq) : 9'd0))
        err_cx++;
      if (cyc < 4) begin
        er = 4'd0; eg = 4'd0; eb = 4'd0; ehs = 1'b1; evs = 1'b1; evo = 1'b0;
      end else begin
        p     = q - 1;
        hp    = p % 800;
        vp    = (p / 800) % 525;
        vis_p = (hp < 640) && (vp < 480);
        er    = vis_p ? 4'(hp) : 4'd0;
        eg    = vis_p ? 4'(vp) : 4'd0;
        eb    = vis_p ? 4'hA : 4'd0;
        ehs   = !(hp >= 656 && hp <= 751);
        evs   = !(vp >= 490 && vp <= 491);
        evo   = vis_p;
      end
      efs = (cyc % 4 == 3) && (hq == 799) && (vq == 524);
      if ({bus_a.r, bus_a.g, bus_a.b} !== {er, eg, eb} || bus_a.video_on !== evo) err_pix++;
      if (bus_a.hs !== ehs || bus_a.vs !== evs || bus_a.frame_start !== efs) err_sync++;
    end
  end

  always @(negedge clk) begin : mon_b
    if (!rstn) begin
      n_vis_b = 0; n_blk_b = 0; fs_n = 0; fs_run = 0; fs_wmax = 0;
      fs_t[0] = -1; fs_t[1] = -1; vs_fall = -1; vs_rise = -1; vs_prev = 1'b1;
    end else begin
      if (cyc > 0 && cyc % 4 == 0) begin
        if (bus_b.video_on) begin
          n_vis_b++;
          if ({bus_b.r, bus_b.g, bus_b.b} !== 12'hFFF) err_blank++;
        end else begin
          n_blk_b++;
          if ({bus_b.r, bus_b.g, bus_b.b} !== 12'h000) err_blank++;
        end
      end
      if (bus_b.frame_start) begin
        if (fs_run == 0) begin
          if (fs_n < 2) fs_t[fs_n] = cyc;
          fs_n++;
        end
        fs_run++;
        if (fs_run > fs_wmax) fs_wmax = fs_run;
      end else begin
        fs_run = 0;
      end
      if (!bus_b.vs && vs_prev && vs_fall < 0) vs_fall = cyc;
      if (bus_b.vs && !vs_prev && vs_fall >= 0 && vs_rise < 0) vs_rise = cyc;
      vs_prev = bus_b.vs;
    end
  end

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) check_val("wait_cyc", cyc, target);
  endtask

  task automatic wait_hs(input logic level, output int t);
    int guard = 0;
    while (bus_a.hs !== level && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    t = cyc;
    if (bus_a.hs !== level) check_val("hs_timeout", 32'(bus_a.hs), 32'(level));
  endtask

  // Entered on the negedge where rstn is released
  task automatic run_sequence();
    int t0, t1, t2;
    repeat (3) @(negedge clk);
    check_val("cx_hold", bus_a.cx, 0);
    @(negedge clk);
    check_val("cx_step", bus_a.cx, 1);
    wait_cyc(4 * 639);
    check_val("cx_last_vis", bus_a.cx, 639);
    wait_cyc(4 * 640);
    check_val("cx_blank", bus_a.cx, 0);
    wait_hs(1'b0, t0);
    check_val("hs_fall", t0, 2628);
    wait_hs(1'b1, t1);
    check_val("hs_low", t1 - t0, 384);
    wait_hs(1'b0, t2);
    check_val("hs_period", t2 - t0, 3200);
    check_val("fs_first", fs_t[0], 1199);
    check_val("fs_period", fs_t[1] - fs_t[0], 1200);
    check_val("fs_width", fs_wmax, 1);
    check_val("vs_fall", vs_fall, 804);
    check_val("vs_low", vs_rise - vs_fall, 200);
    check_val("blank_vis_seen", 32'(n_vis_b > 0), 1);
    check_val("blank_blk_seen", 32'(n_blk_b > 0), 1);
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_hs", bus_a.hs, 1);
    check_val("rst_vs", bus_a.vs, 1);
    check_val("rst_rgb", {bus_a.r, bus_a.g, bus_a.b}, 0);
    check_val("rst_cx", bus_a.cx, 0);
    check_val("rst_cy", bus_a.cy, 0);
    check_val("rst_fs", bus_a.frame_start, 0);
    check_val("rst_von", bus_a.video_on, 0);
    check_val("rst_b_syncs", {bus_b.hs, bus_b.vs}, 2'b11);

    rstn = 1'b1;
    run_sequence();

    // Unit A is now inside an hs low pulse; reset must lift it without a clock edge
    #2 rstn = 1'b0;
    #1;
    check_val("mid_hs_async", bus_a.hs, 1);
    check_val("mid_von", bus_a.video_on, 0);
    check_val("mid_cx", bus_a.cx, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    run_sequence();

    check_val("model_cx_cy", err_cx, 0);
    check_val("model_pixel", err_pix, 0);
    check_val("model_sync", err_sync, 0);
    check_val("model_blank", err_blank, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
